// File: rtl/tmds_pkg.sv
// Shared TMDS constants, types and helpers for the 8b/10b channel encoder.
package tmds_pkg;

    localparam int unsigned TMDS_SYM_W  = 10;
    localparam int unsigned TMDS_DATA_W = 8;
    localparam int unsigned TMDS_CTRL_W = 2;
    localparam int unsigned TMDS_QM_W   = 9;
    localparam int unsigned TMDS_CNT_W  = 5;

    localparam logic [TMDS_SYM_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [TMDS_SYM_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [TMDS_SYM_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [TMDS_SYM_W-1:0] CTRL_11 = 10'b1010101011;

    typedef logic signed [TMDS_CNT_W-1:0] disp_t;

    // Stage-1 output word carried into the DC-balance stage.
    typedef struct packed {
        logic                   de;
        logic [TMDS_CTRL_W-1:0] ctrl;
        logic [TMDS_QM_W-1:0]   qm;
    } qm_word_t;

    function automatic logic [3:0] popcount8(input logic [TMDS_DATA_W-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < int'(TMDS_DATA_W); i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// TMDS stage 1: transition-minimised q_m generation and its pipeline register.
module tmds_qm_stage
    import tmds_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   de,
    input  logic [TMDS_CTRL_W-1:0] ctrl,
    input  logic [TMDS_DATA_W-1:0] data,
    output qm_word_t               word
);

    logic [3:0]           n1d_c;
    logic                 use_xnor_c;
    logic [TMDS_QM_W-1:0] qm_c;

    // XNOR chaining is chosen whenever it yields fewer transitions.
    always_comb begin
        n1d_c      = popcount8(data);
        use_xnor_c = (n1d_c > 4'd4) || ((n1d_c == 4'd4) && !data[0]);
        qm_c       = '0;
        qm_c[0]    = data[0];
        for (int i = 1; i < int'(TMDS_DATA_W); i++) begin
            qm_c[i] = use_xnor_c ? ~(qm_c[i-1] ^ data[i]) : (qm_c[i-1] ^ data[i]);
        end
        qm_c[8] = ~use_xnor_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
        end else begin
            word.de   <= de;
            word.ctrl <= ctrl;
            word.qm   <= qm_c;
        end
    end

endmodule

// File: rtl/tmds_encoder.sv
// DVI/TMDS 8b/10b encoder for one colour channel, two-clock latency.
// Optional raw-symbol bypass enabled by defining TMDS_ENC_BYPASS_EN.
module tmds_encoder
    import tmds_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   de,
    input  logic [TMDS_CTRL_W-1:0] ctrl,
    input  logic [TMDS_DATA_W-1:0] data,
`ifdef TMDS_ENC_BYPASS_EN
    input  logic                   raw_en,
    input  logic [TMDS_SYM_W-1:0]  raw,
`endif
    output logic [TMDS_SYM_W-1:0]  sym
);

    qm_word_t word;

    tmds_qm_stage u_qm_stage (
        .clk  (clk),
        .rst  (rst),
        .de   (de),
        .ctrl (ctrl),
        .data (data),
        .word (word)
    );

`ifdef TMDS_ENC_BYPASS_EN
    logic                  raw_en_q;
    logic [TMDS_SYM_W-1:0] raw_q;

    // Raw symbols ride alongside stage 1 so they keep the same latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_en_q <= 1'b0;
            raw_q    <= '0;
        end else begin
            raw_en_q <= raw_en;
            raw_q    <= raw;
        end
    end
`endif

    disp_t                 cnt;
    disp_t                 cnt_c;
    disp_t                 diff_c;
    logic [TMDS_SYM_W-1:0] sym_c;
    logic [3:0]            n1_c;
    logic [3:0]            n0_c;
    logic                  q8_c;
    logic [7:0]            q_c;

    // Stage 2: DC balancing against the running disparity; diff_c = n1 - n0.
    always_comb begin
        sym_c  = CTRL_00;
        cnt_c  = cnt;
        q8_c   = word.qm[8];
        q_c    = word.qm[7:0];
        n1_c   = popcount8(q_c);
        n0_c   = 4'd8 - n1_c;
        diff_c = disp_t'({1'b0, n1_c}) - disp_t'({1'b0, n0_c});

        if (!word.de) begin
            case (word.ctrl)
                2'b00:   sym_c = CTRL_00;
                2'b01:   sym_c = CTRL_01;
                2'b10:   sym_c = CTRL_10;
                default: sym_c = CTRL_11;
            endcase
            cnt_c = '0;
        end else if ((cnt == '0) || (n1_c == n0_c)) begin
            sym_c = {~q8_c, q8_c, (q8_c ? q_c : ~q_c)};
            cnt_c = q8_c ? (cnt + diff_c) : (cnt - diff_c);
        end else if ((!cnt[4] && (n1_c > n0_c)) || (cnt[4] && (n0_c > n1_c))) begin
            sym_c = {1'b1, q8_c, ~q_c};
            cnt_c = cnt - diff_c + disp_t'({q8_c, 1'b0});
        end else begin
            sym_c = {1'b0, q8_c, q_c};
            cnt_c = cnt + diff_c - disp_t'({~q8_c, 1'b0});
        end

`ifdef TMDS_ENC_BYPASS_EN
        if (raw_en_q) begin
            sym_c = raw_q;
            cnt_c = cnt;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sym <= CTRL_00;
            cnt <= '0;
        end else begin
            sym <= sym_c;
            cnt <= cnt_c;
        end
    end

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: golden model feeds an expected-symbol queue.
module tb_tmds_encoder;

    logic       clk;
    logic       rst;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic [9:0] sym;
`ifdef TMDS_ENC_BYPASS_EN
    logic       raw_en;
    logic [9:0] raw;
`endif

    tmds_encoder dut (
        .clk    (clk),
        .rst    (rst),
        .de     (de),
        .ctrl   (ctrl),
        .data   (data),
`ifdef TMDS_ENC_BYPASS_EN
        .raw_en (raw_en),
        .raw    (raw),
`endif
        .sym    (sym)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] sym;
        int         cnt;
    } sb_t;

    sb_t sbq[$];
    int  mcnt;
    int  errors;
    int  checks;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference encoder; advances the model disparity mcnt.
    function automatic logic [9:0] model(input logic d_en, input logic [1:0] c, input logic [7:0] d);
        logic [8:0] qm;
        logic       use_xnor;
        int         n1d;
        int         n1;
        int         n0;
        logic [9:0] s;
        n1d      = $countones(d);
        use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm       = '0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !use_xnor;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (!d_en) begin
            case (c)
                2'd0:    s = 10'h354;
                2'd1:    s = 10'h0AB;
                2'd2:    s = 10'h154;
                default: s = 10'h2AB;
            endcase
            mcnt = 0;
        end else if (mcnt == 0 || n1 == n0) begin
            s    = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            mcnt = mcnt + (qm[8] ? (n1 - n0) : (n0 - n1));
        end else if ((mcnt > 0 && n1 > n0) || (mcnt < 0 && n0 > n1)) begin
            s    = {1'b1, qm[8], ~qm[7:0]};
            mcnt = mcnt + 2 * int'(qm[8]) + (n0 - n1);
        end else begin
            s    = {1'b0, qm[8], qm[7:0]};
            mcnt = mcnt - 2 * int'(!qm[8]) + (n1 - n0);
        end
        return s;
    endfunction

    task automatic advance();
        sb_t e;
        int  c;
        @(posedge clk);
        #1;
        if (sbq.size() >= 2) begin
            e = sbq.pop_front();
            c = dut.cnt;
            check("sym", int'(sym), int'(e.sym));
            check("cnt", c, e.cnt);
            check("cnt_bound", (c <= 10 && c >= -10) ? 1 : 0, 1);
        end
    endtask

    // want_sym < 0 means take the model's symbol; otherwise a fixed expectation.
    task automatic step(input logic d_en, input logic [1:0] c, input logic [7:0] d,
                        input int want_sym, input int want_cnt);
        sb_t        e;
        logic [9:0] s;
        de   = d_en;
        ctrl = c;
        data = d;
`ifdef TMDS_ENC_BYPASS_EN
        raw_en = 1'b0;
`endif
        s = model(d_en, c, d);
        if (want_sym >= 0) begin
            e.sym = 10'(want_sym);
            e.cnt = want_cnt;
        end else begin
            e.sym = s;
            e.cnt = mcnt;
        end
        sbq.push_back(e);
        advance();
    endtask

`ifdef TMDS_ENC_BYPASS_EN
    task automatic step_raw(input logic [9:0] r);
        sb_t e;
        de     = 1'b1;
        data   = 8'($urandom);
        raw_en = 1'b1;
        raw    = r;
        e.sym  = r;
        e.cnt  = mcnt;
        sbq.push_back(e);
        advance();
        raw_en = 1'b0;
    endtask
`endif

    task automatic restart_scoreboard();
        sb_t e;
        sbq.delete();
        e.sym = 10'h354;
        e.cnt = 0;
        sbq.push_back(e);
        mcnt = 0;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        de   = 1'b1;
        data = 8'($urandom);
        @(posedge clk);
        #1;
        check("rst_sym", int'(sym), 10'h354);
        check("rst_cnt", int'(dut.cnt), 0);
        rst = 1'b0;
        restart_scoreboard();
    endtask

    initial begin
        int len;
        errors = 0;
        checks = 0;
        mcnt   = 0;
        rst    = 1'b1;
        de     = 1'b0;
        ctrl   = 2'd0;
        data   = 8'd0;
`ifdef TMDS_ENC_BYPASS_EN
        raw_en = 1'b0;
        raw    = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_sym", int'(sym), 10'h354);
        check("reset_cnt", int'(dut.cnt), 0);
        rst = 1'b0;
        restart_scoreboard();

        step(1'b0, 2'd0, 8'h00, 10'h354, 0);
        step(1'b0, 2'd1, 8'h00, 10'h0AB, 0);
        step(1'b0, 2'd2, 8'h00, 10'h154, 0);
        step(1'b0, 2'd3, 8'h00, 10'h2AB, 0);

        step(1'b1, 2'd0, 8'h00, 10'h100, -8);
        step(1'b1, 2'd0, 8'h00, 10'h3FF, 2);
        step(1'b1, 2'd0, 8'h00, 10'h100, -6);

        step(1'b0, 2'd0, 8'h00, 10'h354, 0);
        step(1'b1, 2'd0, 8'hFF, 10'h200, -8);
        step(1'b0, 2'd1, 8'h00, 10'h0AB, 0);

        for (int b = 0; b < 400; b++) begin
            len = int'($urandom_range(64, 1));
            for (int k = 0; k < len; k++) begin
                if (b == 150 && k == len / 2)
                    do_reset();
`ifdef TMDS_ENC_BYPASS_EN
                else if ((b % 37) == 5 && k == len / 2)
                    step_raw(10'h2CC);
`endif
                else
                    step(1'b1, 2'd0, 8'($urandom), -1, 0);
            end
            len = int'($urandom_range(3, 1));
            for (int k = 0; k < len; k++)
                step(1'b0, 2'($urandom), 8'($urandom), -1, 0);
        end

        step(1'b0, 2'd0, 8'h00, -1, 0);
        step(1'b0, 2'd0, 8'h00, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
